// File: rtl/dmac_w_sequencer_pkg.sv
// Shared types and widths for the DMAC write-data sequencer.
package DMAC_WSEQ_pkg;

   localparam int ID_W   = 4;
   localparam int LEN_W  = 4;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [LEN_W-1:0] len;
   } wseq_entry_t;

endpackage

// File: rtl/dmac_wseq_fifo.sv
// In-order queue of accepted AW bursts; head is the burst that owns the W channel.
module dmac_wseq_fifo
   import DMAC_WSEQ_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  wseq_entry_t din,
   output logic        full,
   output logic        empty,
   output wseq_entry_t head
);

   localparam int PTR_W = $clog2(DEPTH);

   wseq_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Storage needs no reset: head is only consumed while the queue is non-empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dmac_w_sequencer.sv
// Orders DMAC W data to follow AW order and never interleave bursts.
// Optional sticky beat-count checker enabled by DMAC_WSEQ_ERR_EN.
module dmac_w_sequencer
   import DMAC_WSEQ_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     awvalid_i,
   output logic                     awready_o,
   input  logic [ID_W-1:0]          awid_i,
   input  logic [LEN_W-1:0]         awlen_i,
   output logic                     awvalid_o,
   input  logic                     awready_i,
   input  logic [N_CH-1:0]          wvalid_vec_i,
   input  logic [N_CH*DATA_W-1:0]   wdata_vec_i,
   input  logic [N_CH*STRB_W-1:0]   wstrb_vec_i,
   input  logic [N_CH-1:0]          wlast_vec_i,
   output logic [N_CH-1:0]          wready_vec_o,
   output logic [ID_W-1:0]          wid_o,
   output logic [DATA_W-1:0]        wdata_o,
   output logic [STRB_W-1:0]        wstrb_o,
   output logic                     wlast_o,
   output logic                     wvalid_o,
`ifdef DMAC_WSEQ_ERR_EN
   output logic                     err_o,
`endif
   input  logic                     wready_i
);

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             w_hs;
   wseq_entry_t      head;
   wseq_entry_t      aw_entry;
   logic [LEN_W-1:0] beat_cnt;

   // No full-to-push bypass: a pop in the same cycle does not open the AW path.
   assign awvalid_o = awvalid_i & ~full;
   assign awready_o = awready_i & ~full;
   assign push      = awvalid_o & awready_i;
   assign aw_entry  = '{id: awid_i, len: awlen_i};

   dmac_wseq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (aw_entry),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   // A head id outside the channel range matches nothing and stalls the queue.
   always_comb begin
      wvalid_o     = 1'b0;
      wready_vec_o = '0;
      wid_o        = '0;
      wdata_o      = '0;
      wstrb_o      = '0;
      wlast_o      = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (!empty && head.id == ID_W'(i)) begin
            wvalid_o        = wvalid_vec_i[i];
            wready_vec_o[i] = wready_i;
            wid_o           = head.id;
            wdata_o         = wdata_vec_i[i*DATA_W +: DATA_W];
            wstrb_o         = wstrb_vec_i[i*STRB_W +: STRB_W];
            wlast_o         = wlast_vec_i[i];
         end
      end
   end

   assign w_hs = wvalid_o & wready_i;
   assign pop  = w_hs & wlast_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
      end else if (w_hs) begin
         beat_cnt <= wlast_o ? '0 : beat_cnt + 1'b1;
      end
   end

`ifdef DMAC_WSEQ_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_o <= 1'b0;
      end else if (w_hs && (wlast_o != (beat_cnt == head.len))) begin
         err_o <= 1'b1;
      end
   end
`else
   logic unused_len;
   assign unused_len = ^{beat_cnt, head.len};
`endif

endmodule

// File: tb/tb_dmac_w_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a burst-queue model.
module tb_dmac_w_sequencer;

   localparam int N_CH  = 4;
   localparam int DEPTH = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 awvalid_i, awready_i;
   logic [3:0]           awid_i, awlen_i;
   logic                 awvalid_o, awready_o;
   logic [N_CH-1:0]      wvalid_vec_i, wlast_vec_i, wready_vec_o;
   logic [N_CH*32-1:0]   wdata_vec_i;
   logic [N_CH*4-1:0]    wstrb_vec_i;
   logic [3:0]           wid_o, wstrb_o;
   logic [31:0]          wdata_o;
   logic                 wlast_o, wvalid_o, wready_i;
`ifdef DMAC_WSEQ_ERR_EN
   logic                 err_o;
`endif

   always #5 clk = ~clk;

   dmac_w_sequencer #(.N_CH(N_CH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .awvalid_i    (awvalid_i),
      .awready_o    (awready_o),
      .awid_i       (awid_i),
      .awlen_i      (awlen_i),
      .awvalid_o    (awvalid_o),
      .awready_i    (awready_i),
      .wvalid_vec_i (wvalid_vec_i),
      .wdata_vec_i  (wdata_vec_i),
      .wstrb_vec_i  (wstrb_vec_i),
      .wlast_vec_i  (wlast_vec_i),
      .wready_vec_o (wready_vec_o),
      .wid_o        (wid_o),
      .wdata_o      (wdata_o),
      .wstrb_o      (wstrb_o),
      .wlast_o      (wlast_o),
      .wvalid_o     (wvalid_o),
`ifdef DMAC_WSEQ_ERR_EN
      .err_o        (err_o),
`endif
      .wready_i     (wready_i)
   );

   // Model: the list of outstanding bursts, beats seen on the head burst, sticky error.
   typedef struct {
      int id;
      int len;
   } burst_t;

   burst_t q[$];
   int     beats;
   bit     err_m;
   int     total = 0;
   int     bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set_idle();
      awvalid_i    = 1'b0;
      awready_i    = 1'b1;
      awid_i       = '0;
      awlen_i      = '0;
      wvalid_vec_i = '0;
      wlast_vec_i  = '0;
      wready_i     = 1'b1;
   endtask

   task automatic rand_data();
      for (int c = 0; c < N_CH; c++) begin
         wdata_vec_i[c*32 +: 32] = $urandom;
         wstrb_vec_i[c*4 +: 4]   = 4'($urandom);
      end
   endtask

   // Called just after a falling edge with inputs already driven; checks, then advances one cycle.
   task automatic step();
      bit              full, grant, hs;
      int              ch;
      logic            ev, el;
      logic [31:0]     ed;
      logic [3:0]      es, eid;
      logic [N_CH-1:0] erv;
      #1;
      full  = (q.size() == DEPTH);
      grant = (q.size() != 0) && (q[0].id < N_CH);
      ch    = grant ? q[0].id : 0;
      ev    = grant ? wvalid_vec_i[ch] : 1'b0;
      el    = grant ? wlast_vec_i[ch] : 1'b0;
      ed    = grant ? wdata_vec_i[ch*32 +: 32] : 32'h0;
      es    = grant ? wstrb_vec_i[ch*4 +: 4] : 4'h0;
      eid   = grant ? 4'(ch) : 4'h0;
      erv   = '0;
      if (grant) erv[ch] = wready_i;
      check_val("awvalid_o", 64'(awvalid_o), 64'(awvalid_i & !full));
      check_val("awready_o", 64'(awready_o), 64'(awready_i & !full));
      check_val("wvalid_o", 64'(wvalid_o), 64'(ev));
      check_val("wready_vec_o", 64'(wready_vec_o), 64'(erv));
      check_val("wid_o", 64'(wid_o), 64'(eid));
      check_val("wdata_o", 64'(wdata_o), 64'(ed));
      check_val("wstrb_o", 64'(wstrb_o), 64'(es));
      check_val("wlast_o", 64'(wlast_o), 64'(el));
`ifdef DMAC_WSEQ_ERR_EN
      check_val("err_o", 64'(err_o), 64'(err_m));
`endif
      hs = ev && wready_i;
      @(posedge clk);
      if (hs) begin
         if (el) begin
            if (beats != q[0].len) err_m = 1'b1;
            void'(q.pop_front());
            beats = 0;
         end else begin
            if (beats == q[0].len) err_m = 1'b1;
            beats = (beats + 1) % 16;
         end
      end
      if (awvalid_i && awready_i && !full) q.push_back('{id: int'(awid_i), len: int'(awlen_i)});
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      check_val("rst_wvalid_o", 64'(wvalid_o), 64'(0));
      check_val("rst_wready_vec_o", 64'(wready_vec_o), 64'(0));
`ifdef DMAC_WSEQ_ERR_EN
      check_val("rst_err_o", 64'(err_o), 64'(0));
`endif
      q.delete();
      beats = 0;
      err_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      set_idle();
      awvalid_i = 1'b1;
      rand_data();
      beats = 0;
      err_m = 1'b0;
      #1;
      check_val("rst_awvalid_o", 64'(awvalid_o), 64'(1));
      check_val("rst_awready_o", 64'(awready_o), 64'(1));
      check_val("rst_wvalid_o", 64'(wvalid_o), 64'(0));
      check_val("rst_wid_o", 64'(wid_o), 64'(0));
      check_val("rst_wdata_o", 64'(wdata_o), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      set_idle();

      // Single burst: id 2, four beats, channel 2 already valid during the AW cycle.
      awvalid_i = 1'b1; awid_i = 4'd2; awlen_i = 4'd3;
      wvalid_vec_i = 4'b0100;
      rand_data();
      step();
      awvalid_i = 1'b0;
      for (int b = 0; b < 4; b++) begin
         rand_data();
         wlast_vec_i = (b == 3) ? 4'b0100 : 4'b0000;
         step();
      end
      wlast_vec_i = '0;
      step();

      // Ordering: channel 3 waits behind the earlier channel 1 burst.
      wvalid_vec_i = 4'b1000; wlast_vec_i = 4'b1000;
      awvalid_i = 1'b1; awid_i = 4'd1; awlen_i = 4'd1;
      step();
      awid_i = 4'd3; awlen_i = 4'd0;
      step();
      awvalid_i = 1'b0;
      step();
      wvalid_vec_i = 4'b1010; wlast_vec_i = 4'b1000;
      rand_data();
      step();
      wlast_vec_i = 4'b1010;
      rand_data();
      step();
      rand_data();
      step();
      set_idle();
      step();

      // Full: four AWs with no W traffic, fifth blocked until a pop has registered.
      awvalid_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         awid_i = 4'(k % N_CH); awlen_i = 4'd0;
         step();
      end
      wvalid_vec_i = '1; wlast_vec_i = '1;
      step();
      wvalid_vec_i = '0;
      step();
      awvalid_i = 1'b0;
      wvalid_vec_i = '1;
      for (int k = 0; k < 5; k++) step();
      set_idle();

      // Backpressure on a len=3 burst, then a short-burst error.
      awvalid_i = 1'b1; awid_i = 4'd0; awlen_i = 4'd3;
      step();
      awvalid_i = 1'b0;
      wvalid_vec_i = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         wready_i = ~k[0];
         wlast_vec_i = (k >= 6) ? 4'b0001 : 4'b0000;
         rand_data();
         step();
      end
      set_idle();
      awvalid_i = 1'b1; awid_i = 4'd1; awlen_i = 4'd3;
      step();
      awvalid_i = 1'b0;
      wvalid_vec_i = 4'b0010;
      step();
      wlast_vec_i = 4'b0010;
      step();
      set_idle();
      step();
      step();

      // Reset mid-burst after two of four beats.
      apply_reset();
      awvalid_i = 1'b1; awid_i = 4'd1; awlen_i = 4'd3;
      step();
      awvalid_i = 1'b0;
      wvalid_vec_i = 4'b0010;
      step();
      step();
      wvalid_vec_i = '1;
      apply_reset();
      step();
      set_idle();

      // Randomized traffic.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         awvalid_i    = 1'($urandom_range(0, 1));
         awready_i    = ($urandom_range(0, 3) != 0);
         awid_i       = 4'($urandom_range(0, N_CH - 1));
         awlen_i      = 4'($urandom_range(0, 5));
         wvalid_vec_i = N_CH'($urandom);
         wready_i     = ($urandom_range(0, 3) != 0);
         wlast_vec_i  = '0;
         for (int c = 0; c < N_CH; c++) wlast_vec_i[c] = ($urandom_range(0, 3) == 0);
         if (q.size() != 0 && q[0].id < N_CH)
            wlast_vec_i[q[0].id] = (beats == q[0].len) ^ ($urandom_range(0, 15) == 0);
         rand_data();
         if (cyc % 997 == 500) apply_reset();
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
